// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates a processor (cpu_*) and a host/loader (host_*) requester onto
//   one single-port synchronous memory. One transfer is accepted per cycle,
//   and the memory pipeline is fully pipelined. The host can starve-escape
//   after HOST_WAIT_MAX lost cycles. It can also take exclusive ownership
//   with host_hold: the arbiter drains in-flight work first, then locks the
//   cpu out.
//
// Ports
//   clk_50MHz, reset_n               clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata            cpu request, held stable until cpu_gnt
//   cpu_gnt                          one-cycle accept pulse (combinational)
//   cpu_rvalid/cpu_rdata             read-return pulse and held read data
//   cpu_stall                        cpu is locked out (DRAIN or HOST_OWN)
//   host_req/we/addr/wdata           host request, same handshake as cpu
//   host_gnt/host_rvalid/host_rdata  host accept, read-return pulse, read data
//   host_hold                        host asks for exclusive ownership
//   mem_addr/mem_data/mem_wren       registered memory drive
//   mem_q                            memory read data, one cycle after mem_addr
module mem_arbiter #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 16,
  parameter int HOST_WAIT_MAX = 4
) (
  input  logic              clk_50MHz,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_hold,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int SW = (HOST_WAIT_MAX < 1) ? 1 : $clog2(HOST_WAIT_MAX + 1);
  localparam logic [SW-1:0] WAIT_MAX = SW'(HOST_WAIT_MAX);

  typedef enum logic [1:0] {
    ST_SHARED,
    ST_DRAIN,
    ST_HOST_OWN
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [SW-1:0]     starve_cnt;
  logic              s1_valid, s1_read, s1_host;
  logic              s2_valid, s2_read, s2_host;
  logic              pipe_empty;
  logic              accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign pipe_empty = !s1_valid && !s2_valid;
  assign accept     = cpu_gnt || host_gnt;
  assign sel_we     = host_gnt ? host_we    : cpu_we;
  assign sel_addr   = host_gnt ? host_addr  : cpu_addr;
  assign sel_wdata  = host_gnt ? host_wdata : cpu_wdata;

  // Grants are combinational, so a request is accepted in the cycle it is
  // presented. They are forced low while reset_n is asserted, so that every
  // output reads 0 during reset even if a requester keeps its req high.
  always_comb begin
    state_next = state;
    cpu_gnt    = 1'b0;
    host_gnt   = 1'b0;
    cpu_stall  = (state != ST_SHARED);
    case (state)
      ST_SHARED: begin
        if (host_hold) state_next = ST_DRAIN;
        if (host_req && (!cpu_req || starve_cnt == WAIT_MAX)) host_gnt = 1'b1;
        else                                                 cpu_gnt  = cpu_req;
      end
      ST_DRAIN: begin
        host_gnt = host_req;
        if (!host_hold)      state_next = ST_SHARED;
        else if (pipe_empty) state_next = ST_HOST_OWN;
      end
      ST_HOST_OWN: begin
        host_gnt = host_req;
        if (!host_hold) state_next = ST_SHARED;
      end
      default: state_next = ST_SHARED;
    endcase
    if (!reset_n) begin
      cpu_gnt  = 1'b0;
      host_gnt = 1'b0;
    end
  end

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) state <= ST_SHARED;
    else          state <= state_next;
  end

  // The starve count only advances while the host is actually waiting. It
  // saturates so that the host keeps priority until it is served.
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n)                        starve_cnt <= '0;
    else if (host_gnt || !host_req)      starve_cnt <= '0;
    else if (starve_cnt != WAIT_MAX)     starve_cnt <= starve_cnt + SW'(1);
  end

  // Memory drive and the two-stage in-flight tracker. Stage 1 is the cycle
  // the memory samples mem_addr. Stage 2 is the cycle mem_q carries the
  // read result.
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr <= '0;
      mem_data <= '0;
      mem_wren <= 1'b0;
      s1_valid <= 1'b0;
      s1_read  <= 1'b0;
      s1_host  <= 1'b0;
      s2_valid <= 1'b0;
      s2_read  <= 1'b0;
      s2_host  <= 1'b0;
    end else begin
      if (accept) begin
        mem_addr <= sel_addr;
        mem_data <= sel_wdata;
      end
      mem_wren <= accept && sel_we;
      s1_valid <= accept;
      s1_read  <= accept && !sel_we;
      s1_host  <= host_gnt;
      s2_valid <= s1_valid;
      s2_read  <= s1_read;
      s2_host  <= s1_host;
    end
  end

  // Read return: the owner's rdata captures mem_q while stage 2 holds its
  // read. The data is then held until that owner's next read completes.
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rvalid  <= 1'b0;
      cpu_rdata   <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      cpu_rvalid  <= s2_valid && s2_read && !s2_host;
      host_rvalid <= s2_valid && s2_read && s2_host;
      if (s2_valid && s2_read && !s2_host) cpu_rdata  <= mem_q;
      if (s2_valid && s2_read && s2_host)  host_rdata <= mem_q;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. It contains a behavioural
//   synchronous memory and a reference copy of that memory. A read
//   scoreboard pushes the expected data and due cycle when a read is granted.
//   It pops and compares the entry when an rvalid pulse appears.
//
// Each cycle runs as follows: inputs are driven at posedge+1, and outputs
// are sampled at posedge+5.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk         = 1'b0;
  logic          reset_n     = 1'b0;
  logic          cpu_req     = 1'b0;
  logic          cpu_we      = 1'b0;
  logic [AW-1:0] cpu_addr    = '0;
  logic [DW-1:0] cpu_wdata   = '0;
  logic          host_req    = 1'b0;
  logic          host_we     = 1'b0;
  logic [AW-1:0] host_addr   = '0;
  logic [DW-1:0] host_wdata  = '0;
  logic          host_hold   = 1'b0;
  logic [DW-1:0] mem_q       = '0;
  logic          cpu_gnt, cpu_rvalid, cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_wren;
  logic [61:0]   all_outs;

  assign all_outs = {cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall, host_gnt,
                     host_rvalid, host_rdata, mem_addr, mem_data, mem_wren};

  typedef struct {
    logic          host;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ref_mem [256];
  int            vectors     = 0;
  int            miscompares = 0;
  int            cyc         = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOST_WAIT_MAX(4)) dut (
    .clk_50MHz  (clk),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_hold  (host_hold),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wren   (mem_wren),
    .mem_q      (mem_q)
  );

  always #10 clk = ~clk;

  // Power-up memory contents; address 0x05 holds 0x1234.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return 16'h1234 + {a, a} - 16'h0505;
  endfunction

  // Single-port synchronous memory: mem_q shows the word addressed in the
  // previous cycle. A write lands at the same edge that samples the address.
  bit [DW-1:0] mem_arr     [256];
  bit          mem_written [256];
  always @(posedge clk) begin
    mem_q <= mem_written[mem_addr] ? mem_arr[mem_addr] : pat(mem_addr);
    if (mem_wren) begin
      mem_arr[mem_addr]     <= mem_data;
      mem_written[mem_addr] <= 1'b1;
    end
  end

  task automatic drive_cpu(input logic req, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic drive_host(input logic req, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_req = req; host_we = we; host_addr = a; host_wdata = d;
  endtask

  task automatic settle();
    #4;
  endtask

  // Services the scoreboard for the current (settled) cycle, then moves to
  // posedge+1 of the next cycle.
  task automatic step();
    exp_t e;
    if (!reset_n) begin
      sb.delete();
    end else begin
      if (cpu_rvalid || host_rvalid) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL rvalid_unexpected: cycle %0d cpu_rvalid=%b host_rvalid=%b, required no response",
                   cyc, cpu_rvalid, host_rvalid);
        end else begin
          e = sb.pop_front();
          if (e.due != cyc || cpu_rvalid !== !e.host || host_rvalid !== e.host ||
              (e.host ? host_rdata : cpu_rdata) !== e.data) begin
            miscompares++;
            $display("[TB] FAIL rvalid_check: cycle %0d cpu_rvalid=%b host_rvalid=%b cpu_rdata=%h host_rdata=%h, required host=%b data=%h at cycle %0d",
                     cyc, cpu_rvalid, host_rvalid, cpu_rdata, host_rdata, e.host, e.data, e.due);
          end
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        vectors++;
        miscompares++;
        e = sb.pop_front();
        $display("[TB] FAIL rvalid_missing: cycle %0d no rvalid, required host=%b data=%h at cycle %0d",
                 cyc, e.host, e.data, e.due);
      end
      if (cpu_gnt) begin
        if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
        else        sb.push_back('{1'b0, ref_mem[cpu_addr], cyc + 3});
      end
      if (host_gnt) begin
        if (host_we) ref_mem[host_addr] = host_wdata;
        else         sb.push_back('{1'b1, ref_mem[host_addr], cyc + 3});
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      settle();
      step();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive_cpu(1'b1, 1'b0, 8'h05, '0);
    drive_host(1'b1, 1'b1, 8'h06, 16'h5555);
    host_hold = 1'b1;
    settle();
    vectors++;
    if ({cpu_gnt, host_gnt} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_gnt: cpu_gnt=%b host_gnt=%b, required 0 0", cpu_gnt, host_gnt);
    end
    vectors++;
    if (all_outs !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: outputs=%h, required 0", all_outs);
    end
    step();
    drive_cpu(1'b0, 1'b0, '0, '0);
    drive_host(1'b0, 1'b0, '0, '0);
    host_hold = 1'b0;
    reset_n   = 1'b1;
    settle();
    vectors++;
    if (all_outs !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_release: outputs=%h, required 0", all_outs);
    end
    step();
  endtask

  task automatic test_cpu_read();
    drive_cpu(1'b1, 1'b0, 8'h05, '0);
    settle();
    vectors++;
    if (cpu_gnt !== 1'b1 || host_gnt !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL cpu_read_gnt: cpu_gnt=%b host_gnt=%b, required 1 0", cpu_gnt, host_gnt);
    end
    step();
    drive_cpu(1'b0, 1'b0, '0, '0);
    settle();
    vectors++;
    if (mem_addr !== 8'h05 || mem_wren !== 1'b0 || cpu_gnt !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL cpu_read_mem: mem_addr=%h mem_wren=%b cpu_gnt=%b, required 05 0 0",
               mem_addr, mem_wren, cpu_gnt);
    end
    step();
    settle();
    vectors++;
    if (cpu_rvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL cpu_read_early: cpu_rvalid=%b at N+2, required 0", cpu_rvalid);
    end
    step();
    settle();
    vectors++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h1234) begin
      miscompares++;
      $display("[TB] FAIL cpu_read_data: rvalid=%b rdata=%h, required 1 1234", cpu_rvalid, cpu_rdata);
    end
    step();
    settle();
    vectors++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 16'h1234) begin
      miscompares++;
      $display("[TB] FAIL cpu_read_hold: rvalid=%b rdata=%h, required 0 1234", cpu_rvalid, cpu_rdata);
    end
    step();
  endtask

  task automatic test_host_write();
    drive_host(1'b1, 1'b1, 8'h10, 16'hBEEF);
    settle();
    vectors++;
    if (host_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL host_write_gnt: host_gnt=%b cpu_gnt=%b, required 1 0", host_gnt, cpu_gnt);
    end
    step();
    drive_host(1'b0, 1'b0, '0, '0);
    settle();
    vectors++;
    if (mem_wren !== 1'b1 || mem_addr !== 8'h10 || mem_data !== 16'hBEEF) begin
      miscompares++;
      $display("[TB] FAIL host_write_mem: wren=%b addr=%h data=%h, required 1 10 beef",
               mem_wren, mem_addr, mem_data);
    end
    step();
    drive_cpu(1'b1, 1'b0, 8'h10, '0);
    settle();
    vectors++;
    if (mem_wren !== 1'b0 || cpu_gnt !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL host_write_once: mem_wren=%b cpu_gnt=%b, required 0 1", mem_wren, cpu_gnt);
    end
    step();
    drive_cpu(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      settle();
      vectors++;
      if (host_rvalid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL host_write_rvalid: host_rvalid=%b, required 0", host_rvalid);
      end
      step();
    end
    settle();
    vectors++;
    if (cpu_rdata !== 16'hBEEF) begin
      miscompares++;
      $display("[TB] FAIL host_write_readback: cpu_rdata=%h, required beef", cpu_rdata);
    end
    step();
  endtask

  task automatic test_starvation();
    logic exp_host;
    drive_cpu(1'b1, 1'b0, 8'h01, '0);
    drive_host(1'b1, 1'b0, 8'h20, '0);
    for (int i = 0; i < 15; i++) begin
      settle();
      exp_host = (i % 5 == 4);
      vectors++;
      if (cpu_gnt !== !exp_host || host_gnt !== exp_host) begin
        miscompares++;
        $display("[TB] FAIL starve_pattern: cycle %0d cpu_gnt=%b host_gnt=%b, required %b %b",
                 i, cpu_gnt, host_gnt, !exp_host, exp_host);
      end
      step();
    end
    drive_cpu(1'b0, 1'b0, '0, '0);
    drive_host(1'b0, 1'b0, '0, '0);
    idle(4);
  endtask

  task automatic test_host_hold();
    // c0: cpu read accepted in SHARED
    drive_cpu(1'b1, 1'b0, 8'h03, '0);
    settle();
    vectors++;
    if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hold_c0: cpu_gnt=%b cpu_stall=%b, required 1 0", cpu_gnt, cpu_stall);
    end
    step();
    // c1: hold asserted, still SHARED this cycle
    drive_cpu(1'b0, 1'b0, '0, '0);
    host_hold = 1'b1;
    settle();
    vectors++;
    if (cpu_stall !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hold_c1: cpu_stall=%b, required 0", cpu_stall);
    end
    step();
    // c2: DRAIN, cpu request must be ignored
    drive_cpu(1'b1, 1'b0, 8'h07, '0);
    settle();
    vectors++;
    if (cpu_stall !== 1'b1 || cpu_gnt !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hold_c2: cpu_stall=%b cpu_gnt=%b, required 1 0", cpu_stall, cpu_gnt);
    end
    step();
    // c3: the in-flight cpu read still returns
    settle();
    vectors++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== pat(8'h03) || cpu_gnt !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hold_c3: rvalid=%b rdata=%h cpu_gnt=%b, required 1 %h 0",
               cpu_rvalid, cpu_rdata, cpu_gnt, pat(8'h03));
    end
    step();
    // c4, c5: host owns the memory
    drive_host(1'b1, 1'b1, 8'h30, 16'hCAFE);
    settle();
    vectors++;
    if (host_gnt !== 1'b1 || cpu_gnt !== 1'b0 || cpu_stall !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hold_c4: host_gnt=%b cpu_gnt=%b stall=%b, required 1 0 1",
               host_gnt, cpu_gnt, cpu_stall);
    end
    step();
    drive_host(1'b1, 1'b0, 8'h30, '0);
    settle();
    vectors++;
    if (host_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hold_c5: host_gnt=%b cpu_gnt=%b, required 1 0", host_gnt, cpu_gnt);
    end
    step();
    drive_host(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 2; i++) begin
      settle();
      vectors++;
      if (cpu_gnt !== 1'b0 || cpu_stall !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL hold_own: cpu_gnt=%b stall=%b, required 0 1", cpu_gnt, cpu_stall);
      end
      step();
    end
    // c8: hold released, still HOST_OWN this cycle
    host_hold = 1'b0;
    settle();
    vectors++;
    if (cpu_gnt !== 1'b0 || cpu_stall !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hold_release: cpu_gnt=%b stall=%b, required 0 1", cpu_gnt, cpu_stall);
    end
    step();
    // c9: back in SHARED, cpu granted immediately
    settle();
    vectors++;
    if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hold_shared: cpu_gnt=%b stall=%b, required 1 0", cpu_gnt, cpu_stall);
    end
    step();
    drive_cpu(1'b0, 1'b0, '0, '0);
    settle();
    vectors++;
    if (host_rdata !== 16'hCAFE) begin
      miscompares++;
      $display("[TB] FAIL hold_host_rdata: host_rdata=%h, required cafe", host_rdata);
    end
    step();
    idle(3);
  endtask

  task automatic test_reset_mid_transfer();
    drive_cpu(1'b1, 1'b0, 8'h02, '0);
    settle();
    vectors++;
    if (cpu_gnt !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_gnt: cpu_gnt=%b, required 1", cpu_gnt);
    end
    step();
    drive_cpu(1'b0, 1'b0, '0, '0);
    drive_host(1'b1, 1'b0, 8'h04, '0);
    reset_n = 1'b0;
    settle();
    vectors++;
    if (all_outs !== '0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_outputs: outputs=%h, required 0", all_outs);
    end
    step();
    drive_host(1'b0, 1'b0, '0, '0);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      vectors++;
      if (cpu_rvalid !== 1'b0 || host_rvalid !== 1'b0 || cpu_rdata !== '0) begin
        miscompares++;
        $display("[TB] FAIL rst_mid_discard: cpu_rvalid=%b host_rvalid=%b cpu_rdata=%h, required 0 0 0",
                 cpu_rvalid, host_rvalid, cpu_rdata);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 8; t++) begin
      if (t < 4) drive_cpu(1'b1, 1'b0, AW'(t), '0);
      else       drive_cpu(1'b0, 1'b0, '0, '0);
      settle();
      if (t < 4) begin
        vectors++;
        if (cpu_gnt !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL b2b_gnt: t=%0d cpu_gnt=%b, required 1", t, cpu_gnt);
        end
      end
      vectors++;
      if (t >= 3 && t <= 6) begin
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== pat(AW'(t - 3))) begin
          miscompares++;
          $display("[TB] FAIL b2b_data: t=%0d rvalid=%b rdata=%h, required 1 %h",
                   t, cpu_rvalid, cpu_rdata, pat(AW'(t - 3)));
        end
      end else if (cpu_rvalid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL b2b_idle: t=%0d rvalid=%b, required 0", t, cpu_rvalid);
      end
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(AW'(i));
    @(posedge clk);
    #1;
    test_reset();
    test_cpu_read();
    test_host_write();
    test_starvation();
    test_host_hold();
    test_reset_mid_transfer();
    test_back_to_back();
    idle(6);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL sb_drain: %0d reads outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
